mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Execute-to-memory handoff controller placed directly upstream of `MemStage`. It latches one execute-stage result per instruction and holds it stable at `MemStage`'s inputs. It restarts `MemStage`'s read/write sequencers for each access, stalls the execute stage until `mem_finished`, then presents the memory or ALU result to writeback through a valid/ready handshake. Non-memory instructions bypass `MemStage` with one cycle of latency.

## Interface
- `I`, 20, vector items
- `L`, 8, item width in bits
- `A`, 32, address width
- `TAG_W`, 5, writeback tag width (destination register index)
- `TIMEOUT`, 64, maximum WAIT cycles (only used with `MEM_ACCESS_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ex_valid` / `ex_ready`  in / out  1  execute handshake
- `ex_mem_access`  in  1  instruction touches memory
- `ex_write`  in  1  memory write (else read)
- `ex_op_type`  in  2  bit 1 = vector
- `ex_op_source`  in  1  write source: ALU (1) or register (0)
- `ex_address`  in  A  base address
- `ex_alu_v`, `ex_rd2_v`  in  I×L  vector ALU result and rd2
- `ex_alu_s`, `ex_rd2_s`  in  L  scalar ALU result and rd2
- `ex_tag`  in  TAG_W  destination tag
- `ms_rst`  out  1  active-high restart to `MemStage`
- `ms_op_type`, `ms_op_source`, `ms_address`, `ms_alu_v`, `ms_rd2_v`, `ms_alu_s`, `ms_rd2_s`  out  latched copies
- `ms_write_enable`  out  1
- `ms_finished`  in  1  `mem_finished`
- `ms_scalar`, `ms_vector`  in  L, I×L  `MemStage` read results
- `wb_valid` / `wb_ready`  out / in  1  writeback handshake
- `wb_from_mem`  out  1  result comes from memory (1) or ALU (0)
- `wb_scalar`, `wb_vector`  out  L, I×L  selected result
- `wb_op_type`  out  2
- `wb_tag`  out  TAG_W
- `timeout_err`  out  1  sticky watchdog flag

## Operation
States: IDLE, START, WAIT, HOLD.
- **IDLE:** `ex_ready`=1. On `ex_valid`, latch all `ex_*` inputs.
  - `ex_mem_access`=1 → START.
  - Otherwise → HOLD, with `wb_*` loaded from ALU results and `wb_from_mem`=0.
- **START:** exactly one cycle. `ms_rst`=1 while the latched operands are already driven. → WAIT.
- **WAIT:**
  - `ms_rst`=0.
  - `ms_write_enable` = latched `ex_write`; it is 0 in every other state.
  - On `ms_finished`=1:
    - Capture `ms_scalar`/`ms_vector` into `wb_*` for reads.
    - For writes, `wb_*` carries the latched ALU result.
    - Set `wb_from_mem` = ~write.
    - → HOLD.
- **HOLD:** `wb_valid`=1 and `wb_*` stays stable until `wb_ready`.
  - `ex_ready` = `wb_ready`.
  - On handshake with `ex_valid` in the same cycle, latch the new instruction → START or HOLD as in IDLE (back-to-back, no bubble).
  - On handshake without `ex_valid` → IDLE.
- `ms_rst`=1 in IDLE, START and HOLD. This keeps `MemStage` quiescent and blocks phantom writes.
- `ms_finished` is ignored outside WAIT.
- `wb_ready` is ignored outside HOLD.

## Timing
- Reset (`rst`=0, async): state = IDLE.
  - `ms_rst`=1 (combinational from state), `ex_ready`=1.
  - All other outputs and latched registers are 0.
  - `timeout_err`=0.
- Reset mid-WAIT: the access is abandoned immediately and no `wb_valid` is produced.
- Latency from accept edge:
  - Non-memory: `wb_valid` in the next cycle.
  - Memory: START in cycle +1, WAIT from cycle +2, `wb_valid` one cycle after `ms_finished` is sampled high. The minimum is +3.
- Sustained throughput for non-memory ops: one per cycle when `wb_ready` is held high.
- Same cycle `ms_finished`=1 and watchdog expiry: finished wins and `timeout_err` is not set.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT+1)` counter counts WAIT cycles and clears on entering WAIT.
  - After `TIMEOUT` cycles without `ms_finished`, `timeout_err` is set (sticky until reset) and `wb_*` is zeroed with `wb_from_mem`=1. → HOLD.
- Undefined: the counter is absent, `timeout_err` is tied to 0, and WAIT waits indefinitely.

## Structure
- Package `asip_mem_pkg`:
  - `mem_ctrl_state_t` enum.
  - `OP_VECTOR_BIT` = 1.
  - Default `I`/`L`/`A` localparams shared with `MemStage`.
- Optional sub-module `mem_watchdog` (counter plus sticky flag), instantiated only under the macro.

## Test plan
- Scalar read: addr 0x10, memory holds 0x5A → `ms_rst` high for 1 cycle, WAIT, `wb_scalar`=0x5A, `wb_from_mem`=1, `wb_valid` 1 cycle after `ms_finished`.
- Vector write, `op_source`=1, `ex_alu_v` items 0..19 = 1..20 → `ms_write_enable` high only in WAIT; `wb_from_mem`=0; memory 0x20..0x33 holds 1..20.
- Non-memory op with `ex_alu_s`=0x33, `wb_ready`=1 → `wb_valid` next cycle; three back-to-back ops produce three consecutive `wb_valid` cycles.
- `wb_ready`=0 for 5 cycles in HOLD → `wb_*` stable, `ex_ready`=0, the second instruction is accepted on the cycle `wb_ready` rises.
- `rst` asserted 2 cycles into WAIT → all outputs return to reset values asynchronously, no `wb_valid`, and a subsequent read completes normally.
- With `MEM_ACCESS_TIMEOUT_EN` and `TIMEOUT`=8, `ms_finished` held 0 → `timeout_err`=1 after 8 WAIT cycles, `wb_valid`=1 with zero data; the flag stays set through later ops.

Source files
------------

// File: rtl/asip_mem_pkg.sv
// asip_mem_pkg: shared types and defaults for the execute-to-memory handoff
// controller and MemStage. Bit OP_VECTOR_BIT of an op_type marks a vector op.
package asip_mem_pkg;

  localparam int unsigned DEF_I = 20;
  localparam int unsigned DEF_L = 8;
  localparam int unsigned DEF_A = 32;

  localparam int unsigned OP_VECTOR_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts WAIT cycles of mem_access_ctrl and raises a sticky
// timeout flag when TIMEOUT cycles pass without ms_finished. Instantiated only
// when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic finished,
  output logic expire,
  output logic timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Expiry on the last allowed WAIT cycle; a same-cycle finish wins.
  assign expire = active && !finished && (cnt == CW'(TIMEOUT - 1));

  // WAIT-cycle counter (saturating) and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (active && (cnt != CW'(TIMEOUT))) begin
        cnt <= cnt + CW'(1);
      end
      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: latches one execute result per instruction, drives it to
// MemStage, restarts MemStage per access, and hands the memory or ALU result
// to writeback over a valid/ready handshake. Non-memory ops bypass MemStage.
// Optional watchdog: define MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl
  import asip_mem_pkg::*;
#(
  parameter int unsigned I       = DEF_I,
  parameter int unsigned L       = DEF_L,
  parameter int unsigned A       = DEF_A,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  // execute side
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_mem_access,
  input  logic             ex_write,
  input  logic [1:0]       ex_op_type,
  input  logic             ex_op_source,
  input  logic [A-1:0]     ex_address,
  input  logic [I*L-1:0]   ex_alu_v,
  input  logic [I*L-1:0]   ex_rd2_v,
  input  logic [L-1:0]     ex_alu_s,
  input  logic [L-1:0]     ex_rd2_s,
  input  logic [TAG_W-1:0] ex_tag,
  // MemStage side
  output logic             ms_rst,
  output logic [1:0]       ms_op_type,
  output logic             ms_op_source,
  output logic [A-1:0]     ms_address,
  output logic [I*L-1:0]   ms_alu_v,
  output logic [I*L-1:0]   ms_rd2_v,
  output logic [L-1:0]     ms_alu_s,
  output logic [L-1:0]     ms_rd2_s,
  output logic             ms_write_enable,
  input  logic             ms_finished,
  input  logic [L-1:0]     ms_scalar,
  input  logic [I*L-1:0]   ms_vector,
  // writeback side
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_from_mem,
  output logic [L-1:0]     wb_scalar,
  output logic [I*L-1:0]   wb_vector,
  output logic [1:0]       wb_op_type,
  output logic [TAG_W-1:0] wb_tag,
  output logic             timeout_err
);

  mem_ctrl_state_t  state;
  logic             lat_write;
  logic [TAG_W-1:0] lat_tag;
  logic             accept;
  logic             wd_expire;

  // Handshake and MemStage controls decoded from the registered state
  always_comb begin
    ex_ready        = (state == ST_IDLE) || ((state == ST_HOLD) && wb_ready);
    ms_rst          = (state != ST_WAIT);
    ms_write_enable = (state == ST_WAIT) && lat_write;
    wb_valid        = (state == ST_HOLD);
    accept          = ex_valid && ex_ready;
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_START),
    .active     (state == ST_WAIT),
    .finished   (ms_finished),
    .expire     (wd_expire),
    .timeout_err(timeout_err)
  );
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Control FSM with operand latch and writeback result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      lat_write    <= 1'b0;
      lat_tag      <= '0;
      ms_op_type   <= '0;
      ms_op_source <= 1'b0;
      ms_address   <= '0;
      ms_alu_v     <= '0;
      ms_rd2_v     <= '0;
      ms_alu_s     <= '0;
      ms_rd2_s     <= '0;
      wb_from_mem  <= 1'b0;
      wb_scalar    <= '0;
      wb_vector    <= '0;
      wb_op_type   <= '0;
      wb_tag       <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          // IDLE and HOLD share the accept path so HOLD can chain back-to-back
          if (accept) begin
            lat_write    <= ex_write;
            lat_tag      <= ex_tag;
            ms_op_type   <= ex_op_type;
            ms_op_source <= ex_op_source;
            ms_address   <= ex_address;
            ms_alu_v     <= ex_alu_v;
            ms_rd2_v     <= ex_rd2_v;
            ms_alu_s     <= ex_alu_s;
            ms_rd2_s     <= ex_rd2_s;
            if (ex_mem_access) begin
              state <= ST_START;
            end else begin
              state       <= ST_HOLD;
              wb_from_mem <= 1'b0;
              wb_scalar   <= ex_alu_s;
              wb_vector   <= ex_alu_v;
              wb_op_type  <= ex_op_type;
              wb_tag      <= ex_tag;
            end
          end else if ((state == ST_HOLD) && wb_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ms_finished) begin
            state       <= ST_HOLD;
            wb_op_type  <= ms_op_type;
            wb_tag      <= lat_tag;
            wb_from_mem <= ~lat_write;
            if (lat_write) begin
              wb_scalar <= ms_alu_s;
              wb_vector <= ms_alu_v;
            end else begin
              wb_scalar <= ms_scalar;
              wb_vector <= ms_vector;
            end
          end else if (wd_expire) begin
            // Abandoned access: zero data, tag kept so writeback can retire it
            state       <= ST_HOLD;
            wb_op_type  <= ms_op_type;
            wb_tag      <= lat_tag;
            wb_from_mem <= 1'b1;
            wb_scalar   <= '0;
            wb_vector   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl. The
// bench plays MemStage with a small byte memory.
module tb_mem_access_ctrl;

  localparam int unsigned I     = 20;
  localparam int unsigned L     = 8;
  localparam int unsigned A     = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned TMO   = 8;

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_mem_access;
  logic             ex_write;
  logic [1:0]       ex_op_type;
  logic             ex_op_source;
  logic [A-1:0]     ex_address;
  logic [I*L-1:0]   ex_alu_v;
  logic [I*L-1:0]   ex_rd2_v;
  logic [L-1:0]     ex_alu_s;
  logic [L-1:0]     ex_rd2_s;
  logic [TAG_W-1:0] ex_tag;
  logic             ms_rst;
  logic [1:0]       ms_op_type;
  logic             ms_op_source;
  logic [A-1:0]     ms_address;
  logic [I*L-1:0]   ms_alu_v;
  logic [I*L-1:0]   ms_rd2_v;
  logic [L-1:0]     ms_alu_s;
  logic [L-1:0]     ms_rd2_s;
  logic             ms_write_enable;
  logic             ms_finished;
  logic [L-1:0]     ms_scalar;
  logic [I*L-1:0]   ms_vector;
  logic             wb_valid;
  logic             wb_ready;
  logic             wb_from_mem;
  logic [L-1:0]     wb_scalar;
  logic [I*L-1:0]   wb_vector;
  logic [1:0]       wb_op_type;
  logic [TAG_W-1:0] wb_tag;
  logic             timeout_err;

  logic [7:0] mem [0:255];
  int total;
  int bad;

  mem_access_ctrl #(
    .I(I), .L(L), .A(A), .TAG_W(TAG_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_access(ex_mem_access),
    .ex_write(ex_write), .ex_op_type(ex_op_type), .ex_op_source(ex_op_source),
    .ex_address(ex_address), .ex_alu_v(ex_alu_v), .ex_rd2_v(ex_rd2_v),
    .ex_alu_s(ex_alu_s), .ex_rd2_s(ex_rd2_s), .ex_tag(ex_tag),
    .ms_rst(ms_rst), .ms_op_type(ms_op_type), .ms_op_source(ms_op_source),
    .ms_address(ms_address), .ms_alu_v(ms_alu_v), .ms_rd2_v(ms_rd2_v),
    .ms_alu_s(ms_alu_s), .ms_rd2_s(ms_rd2_s), .ms_write_enable(ms_write_enable),
    .ms_finished(ms_finished), .ms_scalar(ms_scalar), .ms_vector(ms_vector),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_from_mem(wb_from_mem),
    .wb_scalar(wb_scalar), .wb_vector(wb_vector), .wb_op_type(wb_op_type),
    .wb_tag(wb_tag), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ex_valid = 0; ex_mem_access = 0; ex_write = 0; ex_op_type = '0;
    ex_op_source = 0; ex_address = '0; ex_alu_v = '0; ex_rd2_v = '0;
    ex_alu_s = '0; ex_rd2_s = '0; ex_tag = '0;
    ms_finished = 0; ms_scalar = '0; ms_vector = '0; wb_ready = 0;
    #3;
    total++; if (ms_rst !== 1'b1) begin bad++; $display("FAIL reset_ms_rst got=%b exp=1", ms_rst); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    total++; if (ms_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", ms_write_enable); end
    total++; if (ms_address !== '0) begin bad++; $display("FAIL reset_ms_address got=%h exp=0", ms_address); end
    total++; if (wb_scalar !== '0 || wb_from_mem !== 1'b0 || wb_tag !== '0) begin
      bad++; $display("FAIL reset_wb got scalar=%h from_mem=%b tag=%h exp=0", wb_scalar, wb_from_mem, wb_tag);
    end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    step(); step();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_ignore_finished();
    ms_finished = 1; wb_ready = 1;
    step(); step();
    total++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || ms_rst !== 1'b1) begin
      bad++; $display("FAIL idle_ignore got valid=%b ready=%b ms_rst=%b exp 0/1/1", wb_valid, ex_ready, ms_rst);
    end
    ms_finished = 0; wb_ready = 0;
  endtask

  task automatic test_scalar_read();
    mem[8'h10] = 8'h5A;
    wb_ready = 1;
    ex_valid = 1; ex_mem_access = 1; ex_write = 0; ex_op_type = 2'b00;
    ex_op_source = 0; ex_address = 32'h10; ex_tag = 5'd3; ex_alu_s = 8'hEE;
    step();
    ex_valid = 0;
    total++; if (ms_rst !== 1'b1 || ms_address !== 32'h10 || ex_ready !== 1'b0) begin
      bad++; $display("FAIL rd_start got ms_rst=%b addr=%h ready=%b exp 1/10/0", ms_rst, ms_address, ex_ready);
    end
    step();
    total++; if (ms_rst !== 1'b0 || ms_write_enable !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rd_wait got ms_rst=%b we=%b valid=%b exp 0/0/0", ms_rst, ms_write_enable, wb_valid);
    end
    step();
    ms_finished = 1; ms_scalar = mem[ms_address[7:0]];
    #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rd_fin_cycle_valid got=%b exp=0", wb_valid); end
    step();
    ms_finished = 0; ms_scalar = '0;
    total++; if (wb_valid !== 1'b1 || wb_scalar !== 8'h5A || wb_from_mem !== 1'b1 || wb_tag !== 5'd3) begin
      bad++; $display("FAIL rd_result got valid=%b scalar=%h from_mem=%b tag=%0d exp 1/5a/1/3",
                      wb_valid, wb_scalar, wb_from_mem, wb_tag);
    end
    total++; if (ms_rst !== 1'b1) begin bad++; $display("FAIL rd_hold_ms_rst got=%b exp=1", ms_rst); end
    step();
    total++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL rd_done got valid=%b ready=%b exp 0/1", wb_valid, ex_ready);
    end
    wb_ready = 0;
  endtask

  task automatic test_vector_write();
    logic [I*L-1:0] vec;
    int errs;
    for (int k = 0; k < int'(I); k++) vec[k*L +: L] = L'(k + 1);
    wb_ready = 1;
    ex_valid = 1; ex_mem_access = 1; ex_write = 1; ex_op_type = 2'b10;
    ex_op_source = 1; ex_address = 32'h20; ex_alu_v = vec; ex_tag = 5'd9;
    step();
    ex_valid = 0; ex_alu_v = '0;
    total++; if (ms_write_enable !== 1'b0) begin bad++; $display("FAIL wr_start_we got=%b exp=0", ms_write_enable); end
    step();
    total++; if (ms_write_enable !== 1'b1 || ms_op_source !== 1'b1) begin
      bad++; $display("FAIL wr_wait_we got we=%b src=%b exp 1/1", ms_write_enable, ms_op_source);
    end
    if (ms_write_enable === 1'b1) begin
      for (int k = 0; k < int'(I); k++) mem[8'(ms_address[7:0] + 8'(k))] = ms_alu_v[k*L +: L];
    end
    ms_finished = 1;
    step();
    ms_finished = 0;
    total++; if (ms_write_enable !== 1'b0 || wb_valid !== 1'b1 || wb_from_mem !== 1'b0) begin
      bad++; $display("FAIL wr_hold got we=%b valid=%b from_mem=%b exp 0/1/0", ms_write_enable, wb_valid, wb_from_mem);
    end
    total++; if (wb_vector !== vec || wb_op_type !== 2'b10) begin
      bad++; $display("FAIL wr_wb_vector got=%h op=%b exp=%h op=10", wb_vector, wb_op_type, vec);
    end
    errs = 0;
    for (int k = 0; k < int'(I); k++) if (mem[8'h20 + k] !== 8'(k + 1)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL wr_mem got %0d wrong bytes exp 0", errs); end
    step();
    wb_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'h33; vals[1] = 8'h44; vals[2] = 8'h55;
    wb_ready = 1;
    ex_mem_access = 0; ex_write = 0; ex_op_type = 2'b00;
    for (int n = 0; n < 3; n++) begin
      ex_valid = 1; ex_alu_s = vals[n]; ex_tag = 5'(n + 1);
      step();
      total++; if (wb_valid !== 1'b1 || wb_scalar !== vals[n] || wb_tag !== 5'(n + 1) || wb_from_mem !== 1'b0) begin
        bad++; $display("FAIL b2b_%0d got valid=%b scalar=%h tag=%0d from_mem=%b exp 1/%h/%0d/0",
                        n, wb_valid, wb_scalar, wb_tag, wb_from_mem, vals[n], n + 1);
      end
    end
    ex_valid = 0;
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", wb_valid); end
    wb_ready = 0;
  endtask

  task automatic test_backpressure();
    int errs;
    wb_ready = 0;
    ex_valid = 1; ex_mem_access = 0; ex_alu_s = 8'h11; ex_tag = 5'd7;
    step();
    ex_alu_s = 8'h22; ex_tag = 5'd8;
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      if (ex_ready !== 1'b0 || wb_valid !== 1'b1 || wb_scalar !== 8'h11 || wb_tag !== 5'd7) errs++;
      step();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_stall got %0d bad cycles exp 0", errs); end
    wb_ready = 1;
    #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b exp=1", ex_ready); end
    step();
    ex_valid = 0;
    total++; if (wb_valid !== 1'b1 || wb_scalar !== 8'h22 || wb_tag !== 5'd8) begin
      bad++; $display("FAIL bp_second got valid=%b scalar=%h tag=%0d exp 1/22/8", wb_valid, wb_scalar, wb_tag);
    end
    step();
    wb_ready = 0;
  endtask

  task automatic test_reset_mid_wait();
    int errs;
    mem[8'h40] = 8'hC3;
    wb_ready = 1;
    ex_valid = 1; ex_mem_access = 1; ex_write = 0; ex_address = 32'h40; ex_tag = 5'd4;
    step();
    ex_valid = 0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    total++; if (ms_rst !== 1'b1 || ex_ready !== 1'b1 || ms_address !== '0 || wb_valid !== 1'b0 || wb_tag !== '0) begin
      bad++; $display("FAIL rstw_async got ms_rst=%b ready=%b addr=%h valid=%b tag=%0d exp 1/1/0/0/0",
                      ms_rst, ex_ready, ms_address, wb_valid, wb_tag);
    end
    ms_finished = 1;
    @(negedge clk);
    rst = 1'b1;
    ms_finished = 0;
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (wb_valid !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rstw_no_valid got %0d valid cycles exp 0", errs); end
    ex_valid = 1;
    step();
    ex_valid = 0;
    step();
    ms_finished = 1; ms_scalar = mem[ms_address[7:0]];
    step();
    ms_finished = 0; ms_scalar = '0;
    total++; if (wb_valid !== 1'b1 || wb_scalar !== 8'hC3 || wb_from_mem !== 1'b1 || wb_tag !== 5'd4) begin
      bad++; $display("FAIL rstw_reread got valid=%b scalar=%h from_mem=%b tag=%0d exp 1/c3/1/4",
                      wb_valid, wb_scalar, wb_from_mem, wb_tag);
    end
    step();
    wb_ready = 0;
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    wb_ready = 0; ms_finished = 0;
    ex_valid = 1; ex_mem_access = 1; ex_write = 0; ex_address = 32'h50; ex_tag = 5'd6;
    ms_scalar = 8'hFF; ms_vector = '1;
    step();
    ex_valid = 0;
    for (int c = 0; c < int'(TMO); c++) step();
    total++; if (timeout_err !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL tmo_early got err=%b valid=%b exp 0/0", timeout_err, wb_valid);
    end
    step();
    total++; if (timeout_err !== 1'b1 || wb_valid !== 1'b1 || wb_scalar !== '0 || wb_vector !== '0 || wb_from_mem !== 1'b1) begin
      bad++; $display("FAIL tmo_fire got err=%b valid=%b scalar=%h from_mem=%b exp 1/1/0/1",
                      timeout_err, wb_valid, wb_scalar, wb_from_mem);
    end
    ms_scalar = '0; ms_vector = '0;
    wb_ready = 1;
    ex_valid = 1; ex_mem_access = 0; ex_alu_s = 8'h66;
    step();
    ex_valid = 0;
    step();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
    wb_ready = 0;
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_ignore_finished();
    test_scalar_read();
    test_vector_write();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_wait();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
